// File: rtl/oni16_pkg.sv
// rtl/oni16_pkg.sv - shared stack-memory types, error bit indices and default stack limits
package oni16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } stack_state_t;

    localparam int STACK_UNDERFLOW = 0;
    localparam int STACK_OVERFLOW  = 1;

    localparam logic [15:0] DEFAULT_STACK_BOTTOM = 16'h9000;
    localparam logic [15:0] DEFAULT_STACK_TOP    = 16'h9FFF;

    localparam int RAM_AW    = 12;
    localparam int RAM_DEPTH = 4096;

    function automatic logic addr_in_window(input logic [15:0] addr,
                                            input logic [15:0] bottom,
                                            input logic [15:0] top);
        return (addr >= bottom) && (addr <= top);
    endfunction

    // Offset into the stack RAM; only meaningful for in-window addresses.
    function automatic logic [RAM_AW-1:0] ram_index(input logic [15:0] addr,
                                                    input logic [15:0] bottom);
        return RAM_AW'(addr - bottom);
    endfunction

endpackage

// File: rtl/oni16_stack_mem_if.sv
// rtl/oni16_stack_mem_if.sv - request/response handshake bundle between core and stack memory
interface oni16_stack_mem_if;

    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/oni16_stack_ram.sv
// rtl/oni16_stack_ram.sv - 4096x8 single-port synchronous RAM with registered read
module oni16_stack_ram
    import oni16_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:RAM_DEPTH-1];

    // Read register only loads on re so the response holds while the core stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/oni16_stack_mem.sv
// rtl/oni16_stack_mem.sv - bounds-checked stack memory with sticky error flags and low-water mark
module oni16_stack_mem
    import oni16_pkg::*;
#(
    parameter logic [15:0] STACK_BOTTOM = DEFAULT_STACK_BOTTOM,
    parameter logic [15:0] STACK_TOP    = DEFAULT_STACK_TOP
) (
    input  logic                    clk,
    input  logic                    reset,
    oni16_stack_mem_if.slave        bus,
    input  logic                    err_clear,
    output logic [7:0]              err_flags,
    output logic [15:0]             low_water
);

    stack_state_t state, state_next;

    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        rsp_err_q;
    logic [7:0]  ram_rdata;

    logic        accept;
    logic        in_window;
    logic        do_access;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  new_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept = (state == ST_IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Gating with reset keeps a write at the reset edge from landing in RAM.
    assign in_window = addr_in_window(addr_q, STACK_BOTTOM, STACK_TOP);
    assign do_access = (state == ST_ACCESS) && !reset;
    assign ram_we    = do_access && wr_q && in_window;
    assign ram_re    = do_access && !wr_q && in_window;

    always_comb begin
        new_err = 8'h00;
        new_err[STACK_OVERFLOW]  = do_access && wr_q && !in_window;
        new_err[STACK_UNDERFLOW] = do_access && !wr_q && !in_window;
    end

    oni16_stack_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_index(addr_q, STACK_BOTTOM)),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
            err_flags <= 8'h00;
            low_water <= STACK_TOP + 16'd1;
        end else begin
            if (state == ST_ACCESS) begin
                rsp_err_q <= !in_window;
            end
            // A freshly detected error survives a simultaneous clear.
            err_flags <= (err_clear ? 8'h00 : err_flags) | new_err;
            if (ram_we && (addr_q < low_water)) begin
                low_water <= addr_q;
            end
        end
    end

    assign bus.rsp_err   = (state == ST_RESP) && rsp_err_q;
    assign bus.rsp_rdata = ((state == ST_RESP) && !wr_q && !rsp_err_q) ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_oni16_stack_mem.sv
// tb/tb_oni16_stack_mem.sv - directed self-checking bench for oni16_stack_mem
module tb_oni16_stack_mem;

    logic        clk;
    logic        reset;
    logic        err_clear;
    logic [7:0]  err_flags;
    logic [15:0] low_water;

    int tests_run;
    int tests_failed;

    oni16_stack_mem_if bus ();

    oni16_stack_mem #(
        .STACK_BOTTOM (16'h9000),
        .STACK_TOP    (16'h9FFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_clear (err_clear),
        .err_flags (err_flags),
        .low_water (low_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
        check({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        check({tag, "_err_flags"}, err_flags, 8'h00);
        check({tag, "_low_water"}, low_water, 16'hA000);
    endtask

    // Present one request, wait for the response, hand it back, release it.
    task automatic txn(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wd, input logic clr,
                       output logic [7:0] rd, output logic er);
        int lat;
        int waits;
        @(negedge clk);
        waits = 0;
        while (!bus.req_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        err_clear     = clr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) err_clear = 1'b0;
        end while (!bus.rsp_valid && lat < 10);
        err_clear = 1'b0;
        check({tag, "_latency"}, lat, 2);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic       er;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        err_clear     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;

        do_reset();
        check_reset_state("rst");

        // Top boundary write then read-back
        txn("wr_top", 1'b1, 16'h9FFF, 8'hA5, 1'b0, rd, er);
        check("wr_top_rdata", rd, 8'h00);
        check("wr_top_err", er, 1'b0);
        check("wr_top_low_water", low_water, 16'h9FFF);
        txn("rd_top", 1'b0, 16'h9FFF, 8'h00, 1'b0, rd, er);
        check("rd_top_rdata", rd, 8'hA5);
        check("rd_top_err", er, 1'b0);

        // Out-of-window accesses just past each boundary
        txn("wr_bot", 1'b1, 16'h9000, 8'h22, 1'b0, rd, er);
        check("wr_bot_err", er, 1'b0);
        check("wr_bot_low_water", low_water, 16'h9000);
        txn("wr_below", 1'b1, 16'h8FFF, 8'h33, 1'b0, rd, er);
        check("wr_below_err", er, 1'b1);
        check("wr_below_rdata", rd, 8'h00);
        check("wr_below_flags", err_flags, 8'h02);
        check("wr_below_low_water", low_water, 16'h9000);
        txn("rd_bot", 1'b0, 16'h9000, 8'h00, 1'b0, rd, er);
        check("rd_bot_rdata", rd, 8'h22);
        check("rd_bot_err", er, 1'b0);
        txn("rd_above", 1'b0, 16'hA000, 8'h00, 1'b0, rd, er);
        check("rd_above_rdata", rd, 8'h00);
        check("rd_above_err", er, 1'b1);
        check("rd_above_flags", err_flags, 8'h03);

        // Clear coinciding with a new underflow: only the new bit remains
        txn("clr_rd", 1'b0, 16'hA000, 8'h00, 1'b1, rd, er);
        check("clr_rd_err", er, 1'b1);
        check("clr_rd_flags", err_flags, 8'h01);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clr_only_flags", err_flags, 8'h00);

        // Stalled response with an intruding request that must be ignored
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h9FFF;
        @(posedge clk);
        #1;
        bus.req_write = 1'b1;
        bus.req_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_rsp_valid", i), bus.rsp_valid, 1'b1);
            check($sformatf("stall%0d_rdata", i), bus.rsp_rdata, 8'hA5);
            check($sformatf("stall%0d_req_ready", i), bus.req_ready, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        txn("rd_after_stall", 1'b0, 16'h9FFF, 8'h00, 1'b0, rd, er);
        check("rd_after_stall_rdata", rd, 8'hA5);
        check("stall_flags", err_flags, 8'h00);

        // Reset while a write to 16'h9000 is in ACCESS
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h9000;
        bus.req_wdata = 8'h11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("rst_access");
        txn("rd_after_rst", 1'b0, 16'h9000, 8'h00, 1'b0, rd, er);
        check("rd_after_rst_rdata", rd, 8'h22);
        check("rd_after_rst_err", er, 1'b0);

        // Push 01..04 downward, pop back in reverse
        for (int i = 0; i < 4; i++) begin
            txn($sformatf("push%0d", i), 1'b1, 16'h9FFE - 16'(i), 8'(i + 1), 1'b0, rd, er);
            check($sformatf("push%0d_err", i), er, 1'b0);
        end
        check("push_low_water", low_water, 16'h9FFB);
        for (int i = 0; i < 4; i++) begin
            txn($sformatf("pop%0d", i), 1'b0, 16'h9FFB + 16'(i), 8'h00, 1'b0, rd, er);
            check($sformatf("pop%0d_rdata", i), rd, 8'(4 - i));
        end
        check("pop_low_water", low_water, 16'h9FFB);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/oni16_stack_mem.md
ONI16_STACK_MEM -- requirements
Module: oni16_stack_mem

Interface
REQ-001 Parameter STACK_BOTTOM, 16'h9000, lowest valid stack address (inclusive) SHALL be provided.
REQ-002 Parameter STACK_TOP, 16'h9FFF, highest valid stack address (inclusive) SHALL be provided.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_write  input  1  1 = write (PUSH), 0 = read (POP).
REQ-007 req_addr  input  16  byte address, normally the core's SP.
REQ-008 req_wdata  input  8  write data.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  core accepts response.
REQ-012 rsp_rdata  output  8  read data; 8'h00 for writes and errored accesses.
REQ-013 rsp_err  output  1  access rejected by bounds check.
REQ-014 err_flags  output  8  sticky error flags: bit0 STACK_UNDERFLOW, bit1 STACK_OVERFLOW, bits7:2 zero.
REQ-015 err_clear  input  1  clears err_flags.
REQ-016 low_water  output  16  lowest address successfully written since reset.

Function
REQ-017 FSM SHALL have states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on req_valid && req_ready, latch write/addr/wdata, go to ACCESS; else stay.
REQ-019 ACCESS: perform bounds check and the RAM access (one cycle), go to RESP.
REQ-020 RESP: rsp_valid = 1, rsp_rdata/rsp_err stable; on rsp_ready go to IDLE, else stay.
REQ-021 Latency: request accepted at edge N SHALL give rsp_valid high from edge N+2; minimum 3 cycles per transaction.
REQ-022 In-window: STACK_BOTTOM <= addr <= STACK_TOP; RAM index = addr - STACK_BOTTOM, 12 bits.
REQ-023 Out-of-window write: RAM not written, rsp_err = 1, err_flags bit1 set.
REQ-024 Out-of-window read: rsp_rdata = 8'h00, rsp_err = 1, err_flags bit0 set.
REQ-025 Boundary addresses STACK_BOTTOM and STACK_TOP SHALL be valid; STACK_BOTTOM-1 and STACK_TOP+1 SHALL error.
REQ-026 Successful write with addr < low_water SHALL update low_water to addr in ACCESS.
REQ-027 err_clear and a new error in the same cycle: new error bit SHALL win (set), others clear.
REQ-028 Read of never-written in-window address SHALL return RAM content (undefined); bench must not check it.
REQ-029 Read-after-write to same address in back-to-back transactions SHALL return the written value.
REQ-030 req_valid while not in IDLE SHALL be ignored (no queueing).

Reset
REQ-031 Reset SHALL force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 8'h00, rsp_err = 0, err_flags = 8'h00, low_water = STACK_TOP + 1.
REQ-032 Reset in ACCESS or RESP SHALL abandon the transaction; a write in ACCESS at the reset edge SHALL NOT occur.
REQ-033 RAM contents SHALL NOT be reset.

Structure
REQ-034 Package oni16_pkg SHALL hold the state enum, error bit indices (STACK_UNDERFLOW = 0, STACK_OVERFLOW = 1) and default stack limits, shared with the core.
REQ-035 Sub-module oni16_stack_ram: 4096x8 single-port synchronous RAM, one write enable, registered read.

Verification
REQ-036 Write 8'hA5 to 16'h9FFF, then read 16'h9FFF -> rsp_rdata 8'hA5, rsp_err 0, rsp_valid 2 cycles after accept, low_water 16'h9FFF.
REQ-037 Write to 16'h8FFF -> rsp_err 1, err_flags 8'h02, RAM at 16'h9000 unchanged; read 16'hA000 -> rsp_rdata 00, err_flags 8'h03.
REQ-038 Hold rsp_ready 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, extra req_valid ignored.
REQ-039 Assert reset in ACCESS of write 8'h11 to 16'h9000 (previously 8'h22) -> outputs at reset values, later read returns 8'h22.
REQ-040 err_clear together with an out-of-window read -> err_flags 8'h01 regardless of prior bit1.
REQ-041 Push 8'h01..8'h04 to 16'h9FFE down to 16'h9FFB, pop in reverse -> data 04,03,02,01, low_water 16'h9FFB.
